// File: rtl/multicycle_shift_unit.sv
// Iterative shift unit for the execute stage: decodes SLL/SRA/SRL from OP/ALUOP and
// shifts a WIDTH-bit operand by up to MAX_STEP positions per cycle.
module multicycle_shift_unit #(
  parameter int WIDTH    = 32,
  parameter int SHAMT_W  = 5,
  parameter int MAX_STEP = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         OP,
  input  logic [4:0]         ALUOP,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               result_rdy,
  output logic [WIDTH-1:0]   result,
  output logic               illegal,
  output logic [1:0]         state_dbg
);

  // Handshake: start is sampled only in IDLE; busy is high in SHIFT and DONE and
  // stalls the pipeline; result_rdy pulses for the single DONE cycle, and result and
  // illegal then hold until the next accepted start.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_SLL = 2'd0,
    MODE_SRA = 2'd1,
    MODE_SRL = 2'd2
  } mode_e;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               illegal_q, illegal_d;

  logic               dec_legal;
  mode_e              dec_mode;
  logic [SHAMT_W-1:0] step;
  logic [SHAMT_W-1:0] rem_next;

  always_comb begin
    dec_legal = 1'b0;
    dec_mode  = MODE_SLL;
    if (OP == 5'b00000) begin
      case (ALUOP)
        5'b00100: begin dec_legal = 1'b1; dec_mode = MODE_SLL; end
        5'b00101: begin dec_legal = 1'b1; dec_mode = MODE_SRA; end
        5'b00110: begin dec_legal = 1'b1; dec_mode = MODE_SRL; end
        default:  begin dec_legal = 1'b0; dec_mode = MODE_SLL; end
      endcase
    end
  end

  // The comparison is done in int so a MAX_STEP wider than rem cannot truncate.
  assign step     = (int'(rem_q) > MAX_STEP) ? SHAMT_W'(MAX_STEP) : rem_q;
  assign rem_next = rem_q - step;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    work_d    = work_q;
    rem_d     = rem_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d    = data_in;
          rem_d     = shamt;
          mode_d    = dec_mode;
          illegal_d = ~dec_legal;
          state_d   = dec_legal ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        case (mode_q)
          MODE_SRA: work_d = WIDTH'($signed(work_q) >>> step);
          MODE_SRL: work_d = work_q >> step;
          default:  work_d = work_q << step;
        endcase
        rem_d = rem_next;
        if (rem_next == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_SLL;
      work_q    <= '0;
      rem_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      work_q    <= work_d;
      rem_q     <= rem_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign result_rdy = (state_q == ST_DONE);
  assign result     = work_q;
  assign illegal    = illegal_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_shift_unit.sv
// Directed and random checks of multicycle_shift_unit against a simple
// arithmetic model of the shift result and its completion latency.
module tb_multicycle_shift_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [4:0]  OP;
  logic [4:0]  ALUOP;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        result_rdy;
  logic [31:0] result;
  logic        illegal;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  multicycle_shift_unit #(.WIDTH(32), .SHAMT_W(5), .MAX_STEP(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .OP         (OP),
    .ALUOP      (ALUOP),
    .data_in    (data_in),
    .shamt      (shamt),
    .busy       (busy),
    .result_rdy (result_rdy),
    .result     (result),
    .illegal    (illegal),
    .state_dbg  (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic bit ref_legal(input logic [4:0] op, input logic [4:0] aluop);
    return (op == 5'd0) && (aluop == 5'd4 || aluop == 5'd5 || aluop == 5'd6);
  endfunction

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [4:0] aluop,
                                             input logic [31:0] d, input logic [4:0] sh);
    int n;
    n = int'(sh);
    if (!ref_legal(op, aluop)) return d;
    if (aluop == 5'd4) return (n >= 32) ? 32'd0 : (d << n);
    if (aluop == 5'd5) return (n >= 32) ? {32{d[31]}} : 32'($signed(d) >>> n);
    return (n >= 32) ? 32'd0 : (d >> n);
  endfunction

  // Negedges after the accepting edge until result_rdy is seen.
  function automatic int ref_latency(input logic [4:0] op, input logic [4:0] aluop,
                                     input logic [4:0] sh);
    int n;
    if (!ref_legal(op, aluop)) return 1;
    n = (int'(sh) + 3) / 4;
    if (n == 0) n = 1;
    return n + 1;
  endfunction

  task automatic scramble();
    OP      = 5'($urandom_range(0, 31));
    ALUOP   = 5'($urandom_range(0, 31));
    data_in = $urandom;
    shamt   = 5'($urandom_range(0, 31));
  endtask

  task automatic run_op(input logic [4:0] op, input logic [4:0] aluop,
                        input logic [31:0] d, input logic [4:0] sh, input string tag);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    bit          got;
    exp_res = ref_result(op, aluop, d, sh);
    exp_lat = ref_latency(op, aluop, sh);
    @(negedge clock);
    start = 1'b1; OP = op; ALUOP = aluop; data_in = d; shamt = sh;
    @(posedge clock);
    #1;
    start = 1'b0;
    scramble();
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clock);
      lat++;
      if (lat == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (result_rdy) got = 1'b1;
      else scramble();
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_ill"}, 32'(illegal), 32'(!ref_legal(op, aluop)));
    @(negedge clock);
    check({tag, "_idle"}, {30'd0, busy, result_rdy}, 32'd0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int pulse_a;
    int pulse_b;
    int pulses;
    logic [4:0]  r_op;
    logic [4:0]  r_alu;

    reset = 1'b0;
    start = 1'b0;
    OP = '0; ALUOP = '0; data_in = '0; shamt = '0;
    #1;
    check("rst_out", {29'd0, busy, result_rdy, illegal}, 32'd0);
    check("rst_res", result, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    run_op(5'd0, 5'd5, 32'h8000_0010, 5'd5,  "sra");
    check("sra_const", result, 32'hFC00_0000);
    run_op(5'd0, 5'd4, 32'h0000_0001, 5'd31, "sll31");
    check("sll_const", result, 32'h8000_0000);
    run_op(5'd0, 5'd6, 32'hF000_0000, 5'd4,  "srl");
    check("srl_const", result, 32'h0F00_0000);
    run_op(5'd0, 5'd6, 32'hDEAD_BEEF, 5'd0,  "zero");
    run_op(5'd5, 5'd5, 32'h1234_ABCD, 5'd3,  "illegal");
    check("ill_const", result, 32'h1234_ABCD);
    run_op(5'd0, 5'd4, 32'h0000_00F0, 5'd8,  "after_ill");

    // start held high: one acceptance per N+2 = 10 cycles, no double acceptance.
    @(negedge clock);
    start = 1'b1; OP = 5'd0; ALUOP = 5'd4; data_in = 32'h0000_0001; shamt = 5'd31;
    @(posedge clock);
    pulses = 0; pulse_a = 0; pulse_b = 0;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clock);
      if (result_rdy) begin
        pulses++;
        if (pulses == 1) pulse_a = i;
        else pulse_b = i;
        check($sformatf("hold_res%0d", pulses), result, 32'h8000_0000);
      end
      if (i == 19) start = 1'b0;
    end
    check("hold_pulses", 32'(pulses), 32'd2);
    check("hold_first", 32'(pulse_a), 32'd9);
    check("hold_period", 32'(pulse_b - pulse_a), 32'd10);
    @(negedge clock);
    check("hold_idle", 32'(busy), 32'd0);

    // Reset during the third SHIFT cycle discards the operation.
    @(negedge clock);
    start = 1'b1; OP = 5'd0; ALUOP = 5'd5; data_in = 32'h8765_4321; shamt = 5'd31;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_out", {29'd0, busy, result_rdy, illegal}, 32'd0);
    check("mid_rst_res", result, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (result_rdy || busy) pulses++;
    end
    check("mid_no_pulse", 32'(pulses), 32'd0);
    run_op(5'd0, 5'd5, 32'h8765_4321, 5'd13, "post_rst_sra");

    for (int k = 0; k < 20; k++) begin
      r_op  = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      r_alu = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(4, 6));
      run_op(r_op, r_alu, $urandom, 5'($urandom_range(0, 31)), $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
